comm_cmd_arbiter: RTL

- Shares the single UART command master (16-bit cmd sent as high byte then low byte, `snd_cmd`/`cmd_cmplt` handshake) among NUM_REQ independent requesters.
- Arbitrates round-robin and latches the winner's command.
- Issues a one-cycle `snd_cmd` to the command master, then waits for `cmd_cmplt`.
- Returns a per-requester completion pulse to the winner.

---
 rtl/comm_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/comm_cmd_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared types and default sizes for the UART command arbiter slice.
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int CMD_W_DEF   = 16;
    localparam int NUM_REQ_DEF = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible bit searching upward from last_ptr+1 with wrap.
module rr_arbiter
    import comm_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] last_ptr,
    output logic                       vld,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] pos;

    always_comb begin
        vld = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!vld && eligible[pos]) begin
                vld = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/comm_cmd_arbiter.sv
// Round-robin sharing of one UART command master among NUM_REQ requesters.
// Define CMD_TIMEOUT_EN to add a WAIT timeout that forces completion and pulses err.
module comm_cmd_arbiter
    import comm_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int CMD_W       = CMD_W_DEF,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
    input  logic                       cmd_cmplt,
    output logic                       snd_cmd,
    output logic [CMD_W-1:0]           cmd,
    output logic [NUM_REQ-1:0]         ack,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("comm_cmd_arbiter: unsupported parameter set");
    end

    arb_state_t         state;
    logic [IDX_W-1:0]   last_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    logic [NUM_REQ-1:0] eligible;
    logic               tmo_hit;

    // ack is non-zero only in the first IDLE cycle after a completion, so it is exactly the one-cycle mask.
    assign eligible = req & ~ack;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .eligible (eligible),
        .last_ptr (last_gnt),
        .vld      (arb_vld),
        .idx      (arb_idx)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_cnt_nx;

    assign tmo_cnt_nx = tmo_cnt + 1'b1;
    assign tmo_hit    = (state == WAIT) && (tmo_cnt_nx == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= tmo_hit && !cmd_cmplt;
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt_nx;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            snd_cmd  <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            cmd      <= '0;
            gnt_id   <= '0;
            last_gnt <= IDX_W'(NUM_REQ - 1);
        end else begin
            snd_cmd <= 1'b0;
            ack     <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_vld) begin
                        gnt_id  <= arb_idx;
                        cmd     <= req_cmd[int'(arb_idx)*CMD_W +: CMD_W];
                        snd_cmd <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (cmd_cmplt || tmo_hit) begin
                        ack[gnt_id] <= 1'b1;
                        last_gnt    <= gnt_id;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
